// File: rtl/osecpu_sequencer.sv
// rtl/osecpu_sequencer.sv - OSECPU instruction sequencer: fetch over req/ack, one-cycle EXEC, halt/fault/retire status.
// Optional single-step mode (STEP state and step port) is built when OSECPU_SEQ_STEP_EN is defined.
module osecpu_sequencer #(
  parameter int          AW       = 12,
  parameter int unsigned START_PC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
`ifdef OSECPU_SEQ_STEP_EN
  input  logic          step,
`endif
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_data,
  output logic [31:0]   instr0,
  output logic [3:0]    current_state,
  output logic          ireg_we,
  output logic          busy,
  output logic          halted,
  output logic          fault,
  output logic [7:0]    fault_op,
  output logic [31:0]   retired
);

  localparam logic [AW-1:0] START = AW'(START_PC);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_EXEC  = 4'd1,
    S_FETCH = 4'd2,
    S_HALT  = 4'd4,
`ifdef OSECPU_SEQ_STEP_EN
    S_STEP  = 4'd6,
`endif
    S_FAULT = 4'd5
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc;
  logic [7:0]    op_in;
  logic          accept;
  logic          retire;

  function automatic logic op_legal(input logic [7:0] op);
    case (op)
      8'h00, 8'h01, 8'h02, 8'h14, 8'h15, 8'hD2, 8'hD3: op_legal = 1'b1;
      default:                                          op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_writes_ireg(input logic [7:0] op);
    case (op)
      8'h02, 8'h14, 8'h15, 8'hD2: op_writes_ireg = 1'b1;
      default:                    op_writes_ireg = 1'b0;
    endcase
  endfunction

  assign op_in  = imem_data[31:24];
  assign accept = (state == S_FETCH) && imem_ack;
  // END retires at its fetch since it never reaches EXEC
  assign retire = (state == S_EXEC) || (accept && (op_in == 8'hFF));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          if (op_legal(op_in))      state_nxt = S_EXEC;
          else if (op_in == 8'hFF)  state_nxt = S_HALT;
          else                      state_nxt = S_FAULT;
        end
      end
      S_EXEC: begin
        if (stop) state_nxt = S_HALT;
`ifdef OSECPU_SEQ_STEP_EN
        else      state_nxt = S_STEP;
`else
        else      state_nxt = S_FETCH;
`endif
      end
`ifdef OSECPU_SEQ_STEP_EN
      S_STEP: begin
        if (stop)      state_nxt = S_HALT;
        else if (step) state_nxt = S_FETCH;
      end
`endif
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= START;
      instr0   <= 32'd0;
      fault_op <= 8'd0;
      retired  <= 32'd0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE || state == S_HALT) && start) pc <= START;
      if (accept) begin
        instr0 <= imem_data;
        pc     <= pc + AW'(1);
        if (state_nxt == S_FAULT) fault_op <= op_in;
      end
      if (retire && (retired != 32'hFFFF_FFFF)) retired <= retired + 32'd1;
    end
  end

  assign current_state = state;
  assign imem_req      = (state == S_FETCH);
  assign imem_addr     = pc;
  assign ireg_we       = (state == S_EXEC) && op_writes_ireg(instr0[31:24]);
  assign halted        = (state == S_HALT);
  assign fault         = (state == S_FAULT);
  assign busy          = !(state == S_IDLE || state == S_HALT || state == S_FAULT);

endmodule

// File: tb/tb_osecpu_sequencer.sv
// tb/tb_osecpu_sequencer.sv - directed self-checking bench for osecpu_sequencer.
module tb_osecpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, force_ack;
  logic        imem_req, imem_ack, ireg_we, busy, halted, fault;
  logic [11:0] imem_addr;
  logic [31:0] imem_data, instr0, retired;
  logic [3:0]  current_state;
  logic [7:0]  fault_op;
`ifdef OSECPU_SEQ_STEP_EN
  logic        step;
`endif

  logic        start2;
  logic        imem_req2, imem_ack2, ireg_we2, busy2, halted2, fault2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_data2, instr02, retired2;
  logic [3:0]  current_state2;
  logic [7:0]  fault_op2;

  logic [31:0] mem [16];
  logic [3:0]  wcnt;
  logic [3:0]  ack_delay;

  int checks = 0;
  int failures = 0;
  int exec_cnt = 0;
  int we_cnt = 0;
  int n;

  always #5 clk = ~clk;

  osecpu_sequencer #(.AW(12), .START_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
`ifdef OSECPU_SEQ_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr0(instr0), .current_state(current_state), .ireg_we(ireg_we), .busy(busy),
    .halted(halted), .fault(fault), .fault_op(fault_op), .retired(retired)
  );

  osecpu_sequencer #(.AW(2), .START_PC(3)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(1'b0),
`ifdef OSECPU_SEQ_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_data(imem_data2),
    .instr0(instr02), .current_state(current_state2), .ireg_we(ireg_we2), .busy(busy2),
    .halted(halted2), .fault(fault2), .fault_op(fault_op2), .retired(retired2)
  );

  // memory model: ack after ack_delay wait cycles of a held request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wcnt <= 4'd0;
    else if (!imem_req || imem_ack) wcnt <= 4'd0;
    else                           wcnt <= wcnt + 4'd1;
  end
  assign imem_ack   = (imem_req && (wcnt == ack_delay)) || force_ack;
  assign imem_data  = mem[imem_addr[3:0]];
  assign imem_ack2  = imem_req2;
  assign imem_data2 = (imem_addr2 == 2'd3) ? 32'h0000_0000 : 32'hFF00_0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (current_state == 4'd1) exec_cnt++;
    if (ireg_we) we_cnt++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_stopped(output int cycles);
    cycles = 0;
    while (!halted && !fault && cycles < 60) begin
      tick();
      cycles++;
    end
    if (cycles >= 60) check_eq("timeout_wait_stopped", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; force_ack = 1'b0; start2 = 1'b0;
    ack_delay = 4'd0;
`ifdef OSECPU_SEQ_STEP_EN
    step = 1'b1;
`endif
    for (int i = 0; i < 16; i++) mem[i] = 32'hFF00_0000;
    mem[0] = 32'h0204_0005;
    mem[1] = 32'h1484_1040;
    mem[2] = 32'hFF00_0000;
    tick(); tick();

    check_eq("rst_state", {28'd0, current_state}, 32'd0);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_addr", {20'd0, imem_addr}, 32'd0);
    check_eq("rst_instr0", instr0, 32'd0);
    check_eq("rst_flags", {27'd0, ireg_we, busy, halted, fault, 1'b0}, 32'd0);
    check_eq("rst_fault_op", {24'd0, fault_op}, 32'd0);
    check_eq("rst_retired", retired, 32'd0);
    rst_n = 1'b1;
    tick();

    // zero-wait program LIMM16, ADD, END
    exec_cnt = 0; we_cnt = 0;
    pulse_start();
    check_eq("zw_first_req", {31'd0, imem_req}, 32'd1);
    check_eq("zw_first_addr", {20'd0, imem_addr}, 32'd0);
    wait_stopped(n);
`ifdef OSECPU_SEQ_STEP_EN
    check_eq("zw_cycles", n, 32'd7);
`else
    check_eq("zw_cycles", n, 32'd5);
`endif
    check_eq("zw_exec_cnt", exec_cnt, 32'd2);
    check_eq("zw_we_cnt", we_cnt, 32'd2);
    check_eq("zw_halted", {31'd0, halted}, 32'd1);
    check_eq("zw_retired", retired, 32'd3);
    check_eq("zw_pc", {20'd0, imem_addr}, 32'd3);

    // wait states: NOP with ack after 3 wait cycles, then END
    mem[0] = 32'h0000_0000;
    mem[1] = 32'hFF00_0000;
    ack_delay = 4'd3;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check_eq("ws_req_held", {31'd0, imem_req}, 32'd1);
      check_eq("ws_addr_held", {20'd0, imem_addr}, 32'd0);
      check_eq("ws_instr0_old", instr0, 32'hFF00_0000);
      tick();
    end
    check_eq("ws_exec", {28'd0, current_state}, 32'd1);
    check_eq("ws_instr0_new", instr0, 32'h0000_0000);
    check_eq("ws_nop_no_we", {31'd0, ireg_we}, 32'd0);
    wait_stopped(n);
    check_eq("ws_retired", retired, 32'd5);

    // start and stop together from HALT: start wins, stop then halts after one EXEC
    mem[0] = 32'h0204_0005;
    ack_delay = 4'd2;
    exec_cnt = 0; we_cnt = 0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0;
    check_eq("ss_start_wins", {28'd0, current_state}, 32'd2);
    wait_stopped(n);
    stop = 1'b0;
    check_eq("ss_exec_cnt", exec_cnt, 32'd1);
    check_eq("ss_we_cnt", we_cnt, 32'd1);
    check_eq("ss_halted", {31'd0, halted}, 32'd1);
    check_eq("ss_retired", retired, 32'd6);
    check_eq("ss_pc", {20'd0, imem_addr}, 32'd1);

    // ack outside FETCH is ignored
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    check_eq("ack_halt_state", {28'd0, current_state}, 32'd4);
    check_eq("ack_halt_instr0", instr0, 32'h0204_0005);

    // illegal opcode is sticky until reset
    mem[0] = 32'h7F00_0000;
    ack_delay = 4'd0;
    exec_cnt = 0;
    pulse_start();
    wait_stopped(n);
    check_eq("il_fault", {31'd0, fault}, 32'd1);
    check_eq("il_fault_op", {24'd0, fault_op}, 32'h7F);
    check_eq("il_state", {28'd0, current_state}, 32'd5);
    check_eq("il_no_exec", exec_cnt, 32'd0);
    check_eq("il_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    tick();
    check_eq("il_start_ignored", {28'd0, current_state}, 32'd5);
    rst_n = 1'b0;
    tick();
    check_eq("il_rst_fault", {31'd0, fault}, 32'd0);
    check_eq("il_rst_fault_op", {24'd0, fault_op}, 32'd0);
    check_eq("il_rst_retired", retired, 32'd0);
    rst_n = 1'b1;
    tick();

    // reset mid-FETCH drops the request asynchronously
    mem[0] = 32'h0000_0000;
    ack_delay = 4'd5;
    pulse_start();
    check_eq("rf_req_before", {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rf_req_dropped", {31'd0, imem_req}, 32'd0);
    check_eq("rf_state", {28'd0, current_state}, 32'd0);
    check_eq("rf_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    check_eq("rf_idle_after", {28'd0, current_state}, 32'd0);
    check_eq("rf_instr0", instr0, 32'd0);
    check_eq("rf_addr", {20'd0, imem_addr}, 32'd0);

    // PC wrap with AW=2, START_PC=3
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check_eq("wr_first_addr", {30'd0, imem_addr2}, 32'd3);
    @(negedge clk);
    check_eq("wr_exec", {28'd0, current_state2}, 32'd1);
    check_eq("wr_pc_wrapped", {30'd0, imem_addr2}, 32'd0);
    n = 0;
    while (!halted2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("wr_halted", {31'd0, halted2}, 32'd1);
    check_eq("wr_retired", retired2, 32'd2);
    check_eq("wr_final_addr", {30'd0, imem_addr2}, 32'd1);

`ifdef OSECPU_SEQ_STEP_EN
    // single step: NOP, LIMM16, END
    step = 1'b0;
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h0204_0005;
    mem[2] = 32'hFF00_0000;
    ack_delay = 4'd0;
    exec_cnt = 0;
    pulse_start();
    tick();
    tick();
    check_eq("st_wait_state", {28'd0, current_state}, 32'd6);
    repeat (3) tick();
    check_eq("st_hold_state", {28'd0, current_state}, 32'd6);
    check_eq("st_one_exec", exec_cnt, 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    check_eq("st_two_exec", exec_cnt, 32'd2);
    check_eq("st_back_in_step", {28'd0, current_state}, 32'd6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("st_stop_halts", {31'd0, halted}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
